// File: rtl/ms_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ms_pkg
// Description : Shared state encoding and default geometry for the
//               main-store access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ms_pkg;

    localparam int c_word_length = 20;
    localparam int c_addr_bits   = 5;
    localparam int c_digit_div   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } ms_state_t;

endpackage
`default_nettype wire

// File: rtl/ms_digit_timer.sv
`default_nettype none
// ============================================================================
// Module      : ms_digit_timer
// Description : Digit-period divider plus digit counter; flags the pulse
//               cycle, the cycle before it, and the last digit of a scan.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_digit_timer
    import ms_pkg::*;
#(
    parameter int WORD_LENGTH = c_word_length,
    parameter int DIGIT_DIV   = c_digit_div
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_enable,
    output logic                           o_dpg_cycle,
    output logic                           o_pre_dpg,
    output logic [$clog2(WORD_LENGTH)-1:0] o_digit,
    output logic                           o_last_digit
);

    localparam int DIV_W   = $clog2(DIGIT_DIV);
    localparam int DIGIT_W = $clog2(WORD_LENGTH);

    localparam logic [DIV_W-1:0]   c_div_last   = DIV_W'(DIGIT_DIV - 1);
    localparam logic [DIV_W-1:0]   c_div_pre    = DIV_W'(DIGIT_DIV - 2);
    localparam logic [DIGIT_W-1:0] c_digit_last = DIGIT_W'(WORD_LENGTH - 1);

    logic [DIV_W-1:0]   r_div;
    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_div   <= '0;
            r_digit <= '0;
        end else if (i_enable) begin
            if (r_div == c_div_last) begin
                r_div   <= '0;
                r_digit <= (r_digit == c_digit_last) ? '0 : r_digit + DIGIT_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // pre_dpg lets the owner register ms_dpg so it lands on the last cycle
    assign o_dpg_cycle  = i_enable && (r_div == c_div_last);
    assign o_pre_dpg    = i_enable && (r_div == c_div_pre);
    assign o_digit      = r_digit;
    assign o_last_digit = (r_digit == c_digit_last);

endmodule
`default_nettype wire

// File: rtl/ms_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ms_access_sequencer
// Description : Sole master of the main-store pins; runs one bit-serial read
//               or write scan per request. MS_CLEAR_BEFORE_WRITE_EN adds a
//               clear scan ahead of every write.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_access_sequencer
    import ms_pkg::*;
#(
    parameter int WORD_LENGTH = c_word_length,
    parameter int ADDR_BITS   = c_addr_bits,
    parameter int DIGIT_DIV   = c_digit_div
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [WORD_LENGTH-1:0] req_data,
    output logic                   rsp_valid,
    output logic [WORD_LENGTH-1:0] rsp_data,
    output logic [ADDR_BITS-1:0]   ms_addr,
    output logic                   ms_xtb,
    output logic                   ms_dpg,
    output logic                   ms_zero,
    output logic                   ms_data_in,
    input  logic                   ms_data_out
);

    localparam int DIGIT_W = $clog2(WORD_LENGTH);

    ms_state_t r_state;
    ms_state_t w_state_next;

    logic                   w_start;
    logic                   w_enable;
    logic                   w_dpg_cycle;
    logic                   w_pre_dpg;
    logic [DIGIT_W-1:0]     w_digit;
    logic                   w_last_digit;
    logic                   w_accept;
    logic                   w_scan_end;
    logic                   w_strobe_next;

    logic                   r_write;
    logic [WORD_LENGTH-1:0] r_wr_word;
    logic [WORD_LENGTH-1:0] r_sh;
    logic [WORD_LENGTH-1:0] r_rd_word;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [WORD_LENGTH-1:0] r_rsp_data;
    logic [ADDR_BITS-1:0]   r_ms_addr;
    logic                   r_ms_xtb;
    logic                   r_ms_dpg;
    logic                   r_ms_data_in;

    ms_digit_timer #(
        .WORD_LENGTH (WORD_LENGTH),
        .DIGIT_DIV   (DIGIT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_enable     (w_enable),
        .o_dpg_cycle  (w_dpg_cycle),
        .o_pre_dpg    (w_pre_dpg),
        .o_digit      (w_digit),
        .o_last_digit (w_last_digit)
    );

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_scan_end = (r_state == ST_SCAN) && w_dpg_cycle;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_enable     = (r_state == ST_ADDR) || (r_state == ST_CLEAR) || (r_state == ST_SCAN);
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = ST_ADDR;
                    w_start      = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_dpg_cycle) begin
                    w_start = 1'b1;
`ifdef MS_CLEAR_BEFORE_WRITE_EN
                    w_state_next = r_write ? ST_CLEAR : ST_SCAN;
`else
                    w_state_next = ST_SCAN;
`endif
                end
            end
            ST_CLEAR: begin
                if (w_dpg_cycle && w_last_digit) begin
                    w_state_next = ST_SCAN;
                    w_start      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_dpg_cycle && w_last_digit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_strobe_next = (w_state_next == ST_SCAN) || (w_state_next == ST_CLEAR);

    // Outputs are loaded from next-state values so every pin comes off a flop
    // yet stays cycle-aligned with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_wr_word    <= '0;
            r_sh         <= '0;
            r_rd_word    <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_ms_addr    <= '0;
            r_ms_xtb     <= 1'b0;
            r_ms_dpg     <= 1'b0;
            r_ms_data_in <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == ST_IDLE);
            r_rsp_valid <= (w_state_next == ST_DONE);

            if (w_accept) begin
                r_write   <= req_write;
                r_wr_word <= req_data;
                r_sh      <= req_data;
                r_ms_addr <= req_addr;
            end else if (w_state_next == ST_IDLE) begin
                r_ms_addr <= '0;
            end

            if (w_scan_end) begin
                r_sh <= {1'b0, r_sh[WORD_LENGTH-1:1]};
                if (!r_write) begin
                    r_rd_word[w_digit] <= ms_data_out;
                end
            end

            if (w_scan_end && w_last_digit) begin
                r_rsp_data <= r_write ? r_wr_word
                                      : {ms_data_out, r_rd_word[WORD_LENGTH-2:0]};
            end

            r_ms_xtb <= r_write && w_strobe_next;
            r_ms_dpg <= w_pre_dpg && w_strobe_next;

            if (r_write && (w_state_next == ST_SCAN)) begin
                r_ms_data_in <= w_scan_end ? r_sh[1] : r_sh[0];
            end else begin
                r_ms_data_in <= 1'b0;
            end
        end
    end

`ifdef MS_CLEAR_BEFORE_WRITE_EN
    logic r_ms_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_zero <= 1'b0;
        end else begin
            r_ms_zero <= (w_state_next == ST_CLEAR);
        end
    end

    assign ms_zero = r_ms_zero;
`else
    assign ms_zero = 1'b0;
`endif

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign ms_addr    = r_ms_addr;
    assign ms_xtb     = r_ms_xtb;
    assign ms_dpg     = r_ms_dpg;
    assign ms_data_in = r_ms_data_in;

endmodule
`default_nettype wire

// File: tb/tb_ms_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ms_access_sequencer
// Description : Directed plus random request bench with an ideal store model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ms_access_sequencer;

    localparam int WL = 20;
    localparam int AB = 5;
    localparam int DD = 4;
`ifdef MS_CLEAR_BEFORE_WRITE_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [WL-1:0] req_data = '0;
    logic          rsp_valid;
    logic [WL-1:0] rsp_data;
    logic [AB-1:0] ms_addr;
    logic          ms_xtb;
    logic          ms_dpg;
    logic          ms_zero;
    logic          ms_data_in;
    logic          ms_data_out = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [WL-1:0] mem [0:(1<<AB)-1];

    always #5 clk = ~clk;

    ms_access_sequencer #(
        .WORD_LENGTH (WL),
        .ADDR_BITS   (AB),
        .DIGIT_DIV   (DD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ms_addr     (ms_addr),
        .ms_xtb      (ms_xtb),
        .ms_dpg      (ms_dpg),
        .ms_zero     (ms_zero),
        .ms_data_in  (ms_data_in),
        .ms_data_out (ms_data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge. Issues one request and follows it to DONE
    // (or to the abort cycle), checking the pin behaviour on every cycle.
    task automatic run_op(input bit wr, input logic [AB-1:0] addr, input logic [WL-1:0] data,
                          input int abort_at, input int exp_wait, input bit chain,
                          input bit nwr, input logic [AB-1:0] naddr, input logic [WL-1:0] ndata);
        int            waited, c, pulses, zpulses, xtb_cyc, din_err, addr_err, xtb_err, rsp_cyc, k, stray;
        int            lat, scans;
        bit            done;
        logic          exp_din;
        logic [WL-1:0] exp_rsp;

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        waited = 0;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (exp_wait >= 0) check("accept_wait", waited, exp_wait);
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);

        exp_rsp = wr ? data : mem[addr];
        scans   = (wr && CLR) ? 2 : 1;
        lat     = DD * (scans * WL + 1) + 1;
        c = 0; pulses = 0; zpulses = 0; xtb_cyc = 0; din_err = 0; addr_err = 0; xtb_err = 0;
        rsp_cyc = -1; done = 1'b0;

        while (!done && c < 400) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                if (chain) begin
                    req_write = nwr;
                    req_addr  = naddr;
                    req_data  = ndata;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_strobes", {ms_xtb, ms_dpg, ms_zero, ms_data_in, rsp_valid}, 5'b0);
                check("abort_addr", ms_addr, 0);
                check("abort_ready", req_ready, 1);
                rst = 1'b0;
                stray = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (rsp_valid || ms_dpg || ms_xtb) stray++;
                end
                check("abort_quiet", stray, 0);
                return;
            end
            if (ms_addr !== addr) addr_err++;
            if (ms_xtb) xtb_cyc++;
            if (wr && ms_dpg && !ms_xtb) xtb_err++;
            k = pulses - zpulses;
            exp_din = (wr && ms_xtb && !ms_zero && k < WL) ? data[k] : 1'b0;
            if (ms_data_in !== exp_din) din_err++;
            if (ms_dpg) begin
                pulses++;
                if (ms_zero) zpulses++;
                ms_data_out = (!wr && pulses <= WL) ? mem[addr][pulses-1] : 1'($urandom);
            end else begin
                ms_data_out = 1'($urandom);
            end
            if (rsp_valid) begin
                done    = 1'b1;
                rsp_cyc = c;
            end
        end
        ms_data_out = 1'b0;

        check("rsp_latency", rsp_cyc, lat);
        check("rsp_data", rsp_data, exp_rsp);
        check("dpg_pulses", pulses, scans * WL);
        check("zero_pulses", zpulses, (wr && CLR) ? WL : 0);
        check("xtb_cycles", xtb_cyc, wr ? scans * WL * DD : 0);
        check("xtb_at_pulse", xtb_err, 0);
        check("data_in_seq", din_err, 0);
        check("addr_held", addr_err, 0);
        if (wr) mem[addr] = data;
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = WL'($urandom);
        mem[7] = 20'hF0F0F;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // quiet idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_state",
                  {1'b0, req_ready, rsp_valid, ms_xtb, ms_dpg, ms_zero, ms_data_in, ms_addr, rsp_data},
                  {1'b0, 1'b1, 5'b0, {AB{1'b0}}, {WL{1'b0}}});
        end

        // directed write then read
        run_op(1'b1, 5'd3, 20'h5A5A5, -1, -1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_op(1'b0, 5'd7, 20'h00000, -1, -1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("post_done_idle", {req_ready, ms_addr, ms_xtb}, {1'b1, {AB{1'b0}}, 1'b0});

        // back-to-back with req_valid held: read then write
        run_op(1'b0, 5'd3, 20'h00000, -1, -1, 1'b1, 1'b1, 5'd12, 20'h13579);
        run_op(1'b1, 5'd12, 20'h13579, -1, 1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // abort at digit 10 of a write
        run_op(1'b1, 5'd20, 20'hABCDE, DD + 10 * DD + 3, -1, 1'b0, 1'b0, '0, '0);
        run_op(1'b0, 5'd12, 20'h00000, -1, 0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // single-bit write and its read-back
        run_op(1'b1, 5'd0, 20'h00001, -1, -1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_op(1'b0, 5'd0, 20'h00000, -1, -1, 1'b0, 1'b0, '0, '0);

        // random mix
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(1'($urandom), AB'($urandom), WL'($urandom), -1, -1, 1'b0, 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
